// File: rtl/mmio_uart_pkg.sv
// ---------------------------------------------------------------------------
// mmio_uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - uart_state_e : transmitter FSM states (PARITY only exists when the
//                    UART_TX_PARITY_EN macro is defined)
//   - register byte offsets relative to BASE_ADDR
//   - STATUS register bit positions
// ---------------------------------------------------------------------------
package mmio_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

  // Register offsets from BASE_ADDR
  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  // STATUS bit positions
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_LINE    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_MSB = 11;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx_if
// Core-side store/load bus bundle for the UART transmitter.
//   MemWrite  : one-cycle store strobe
//   DataAdr   : byte address
//   WriteData : store data
//   ReadData  : combinational read data for DataAdr
//
// Handshake: MemWrite is a valid-only strobe with an implicit ready that is
// always 1 -- every cycle with MemWrite=1 is a complete transfer, there is
// no back-pressure. A store that cannot be accepted (TXDATA while the FIFO is
// full) is dropped and flagged in STATUS instead of being stalled.
// ---------------------------------------------------------------------------
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output DataAdr,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  DataAdr,
    input  WriteData,
    output ReadData
  );
endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO, DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, reset (synchronous, active-low)
//   push/din   : write request; accepted when not full, or when full and a
//                pop happens in the same cycle
//   pop/dout   : read request (ignored when empty); dout shows the head
//   full, empty, count
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop frees the slot being written, so a full FIFO can take a push then.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through count/pointers.
  always_ff @(posedge clk) begin
    if (reset && push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter with a transmit FIFO.
//   BASE_ADDR+0 TXDATA (W)  : WriteData[7:0] pushed into the FIFO
//   BASE_ADDR+4 STATUS (R/W): bit0 full, bit1 empty, bit2 line active,
//                             bit3 sticky overflow (write 1 to clear),
//                             bits[11:8] FIFO count
// Ports:
//   clk, reset (synchronous, active-low)
//   MemWrite, DataAdr, WriteData : core store bus
//   ReadData                     : combinational read of DataAdr
//   tx                           : registered serial line, idle high
//   busy                         : frame on the line or FIFO non-empty
// Config macro: UART_TX_PARITY_EN adds an even-parity bit (11-bit frame).
//
// Timing note: tx is registered from the current FSM state, so the line
// lags the state by one cycle. A byte stored at edge N is popped at N+1
// (IDLE->START) and tx goes low at N+2.
// ---------------------------------------------------------------------------
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        busy
);
  localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                CNT_W       = $clog2(FIFO_DEPTH) + 1;

  // ---------------- address decode ----------------
  logic wr_txdata, wr_status, rd_status;
  assign wr_txdata = MemWrite && (DataAdr == BASE_ADDR + TXDATA_OFS);
  assign wr_status = MemWrite && (DataAdr == BASE_ADDR + STATUS_OFS);
  assign rd_status = (DataAdr == BASE_ADDR + STATUS_OFS);

  logic unused_wdata;
  assign unused_wdata = ^WriteData[31:8];

  // ---------------- FIFO ----------------
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .din   (WriteData[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- FSM / baud / shift ----------------
  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic              tx_q, tx_d;
  logic              line_q, line_d;
  logic              ovf_q, ovf_d;
  logic              bit_done;

  assign bit_done = (baud_q == '0);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_dout;
          baud_d   = BAUD_RELOAD;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          baud_d  = BAUD_RELOAD;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          // Chain straight into the next START so frames abut with no gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_dout;
            baud_d   = BAUD_RELOAD;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line value for the current state; registered into tx_q.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[bit_q];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = ^data_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // line_q covers the final stop-bit cycle, which is still on the wire
  // after the FSM has already returned to IDLE.
  assign line_d = (state_q != ST_IDLE);

  // A drop in the same cycle as a clear wins, so the event is never lost.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && WriteData[STAT_OVF]) ovf_d = 1'b0;
    if (wr_txdata && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'd0;
      tx_q    <= 1'b1;
      line_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      line_q  <= line_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------- outputs ----------------
  logic        line_active;
  logic [31:0] status;

  assign line_active = line_q || (state_q != ST_IDLE);
  assign tx          = tx_q;
  assign busy        = line_active || !fifo_empty;

  always_comb begin
    status                            = 32'd0;
    status[STAT_FULL]                 = fifo_full;
    status[STAT_EMPTY]                = fifo_empty;
    status[STAT_LINE]                 = line_active;
    status[STAT_OVF]                  = ovf_q;
    status[STAT_CNT_MSB:STAT_CNT_LSB] = 4'(fifo_count);
  end

  assign ReadData = rd_status ? status : 32'd0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
// Bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4. A line monitor
// decodes every frame by mid-bit sampling and compares it with a frame built
// from the expected-byte queue (start 0, LSB-first data, optional even
// parity, stop 1). Directed sections cover exact timing, back-to-back
// frames, overflow, full-with-pop acceptance and reset; a random section
// sends bursts of random bytes.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] STAT  = 32'h0000_1004;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic tx, busy;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (bus_if.MemWrite),
    .DataAdr   (bus_if.DataAdr),
    .WriteData (bus_if.WriteData),
    .ReadData  (bus_if.ReadData),
    .tx        (tx),
    .busy      (busy)
  );

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference frame: bit k of the result is the k-th bit time on the line.
  function automatic logic [31:0] model_frame(input logic [7:0] b);
    logic [31:0] f;
    int          ones;
    f    = 32'd0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[1 + i] = b[i];
      if (b[i]) ones++;
    end
`ifdef UART_TX_PARITY_EN
    f[9]  = (ones % 2 == 1);
`endif
    f[NBITS - 1] = 1'b1;
    return f;
  endfunction

  // ---------------- line monitor ----------------
  bit          mon_active = 0;
  int          mon_ph     = 0;
  logic [31:0] mon_bits;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1;
        mon_ph     = 0;
        mon_bits   = 32'd0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_ph++;
      if (mon_ph % CPB == CPB / 2) begin
        mon_bits[mon_ph / CPB] = tx;
        if (mon_ph / CPB == NBITS - 1) begin
          mon_active = 0;
          if (exp_q.size() == 0) begin
            check_eq("frame_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            check_eq("frame", mon_bits, model_frame(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, output int wr_edge);
    bus_if.MemWrite  = 1'b1;
    bus_if.DataAdr   = addr;
    bus_if.WriteData = data;
    @(posedge clk);
    #1;
    wr_edge          = cyc;
    bus_if.MemWrite  = 1'b0;
    bus_if.DataAdr   = STAT;
    bus_if.WriteData = 32'd0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [23:0] hi, output int wr_edge);
    bus_write(BASE, {hi, b}, wr_edge);
    exp_q.push_back(b);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus_if.DataAdr = addr;
    #1;
    data = bus_if.ReadData;
  endtask

  task automatic wait_neg(input int e);
    do @(negedge clk); while (cyc < e);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0 && busy === 1'b0) break;
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          n, n0, e;
    int          len, gap;

    bus_if.MemWrite  = 1'b0;
    bus_if.DataAdr   = STAT;
    bus_if.WriteData = 32'd0;

    // Reset with a TXDATA store held active throughout: must be ignored.
    bus_if.MemWrite  = 1'b1;
    bus_if.DataAdr   = BASE;
    bus_if.WriteData = 32'h0000_00E7;
    idle(3);
    bus_if.MemWrite  = 1'b0;
    bus_read(STAT, rd);
    check_eq("reset_status", rd, 32'h0000_0002);
    check_eq("reset_tx", {31'd0, tx}, 32'd1);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    // Quiet line after release
    idle(20);
    check_eq("idle_tx", {31'd0, tx}, 32'd1);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    bus_read(STAT, rd);
    check_eq("idle_status", rd, 32'h0000_0002);
    bus_read(BASE, rd);
    check_eq("read_txdata_zero", rd, 32'd0);
    bus_read(32'h0000_1008, rd);
    check_eq("read_unmapped_zero", rd, 32'd0);
    check_eq("idle_no_frame", 32'(start_q.size()), 32'd0);

    // Single frame 0xA5 with exact timing
    start_q.delete();
    send_byte(8'hA5, 24'h0, n);
    wait_neg(n + 1);
    check_eq("a5_pre_tx", {31'd0, tx}, 32'd1);
    check_eq("a5_pre_busy", {31'd0, busy}, 32'd1);
    bus_read(STAT, rd);
    check_eq("a5_status_active", rd, 32'h0000_0006);
    wait_neg(n + 2);
    check_eq("a5_start_first", {31'd0, tx}, 32'd0);
    wait_neg(n + 5);
    check_eq("a5_start_last", {31'd0, tx}, 32'd0);
    wait_neg(n + 6);
    check_eq("a5_bit0", {31'd0, tx}, 32'd1);
    wait_neg(n + 10);
    check_eq("a5_bit1", {31'd0, tx}, 32'd0);
    wait_neg(n + FRAME + 1);
    check_eq("a5_stop_tx", {31'd0, tx}, 32'd1);
    check_eq("a5_stop_busy", {31'd0, busy}, 32'd1);
    wait_neg(n + FRAME + 2);
    check_eq("a5_busy_fall", {31'd0, busy}, 32'd0);
    check_eq("a5_start_edge", 32'(start_q[0]), 32'(n + 2));

    // Five consecutive stores: back-to-back frames, no overflow
    idle(5);
    start_q.delete();
    send_byte(8'h01, 24'h0, n0);
    for (int k = 2; k <= 5; k++) send_byte(8'(k), 24'h0, e);
    bus_read(STAT, rd);
    check_eq("burst5_status", rd, 32'h0000_0405);
    wait_idle("burst5");
    check_eq("burst5_frames", 32'(start_q.size()), 32'd5);
    check_eq("burst5_first_start", 32'(start_q[0]), 32'(n0 + 2));
    for (int k = 1; k < start_q.size(); k++)
      check_eq("burst5_gap", 32'(start_q[k] - start_q[k-1]), 32'(FRAME));

    // Overflow, write-1-to-clear, and full-with-pop acceptance
    idle(3);
    send_byte(8'h11, 24'h0, n0);
    send_byte(8'h22, 24'h0, e);
    send_byte(8'h33, 24'h0, e);
    send_byte(8'h44, 24'h0, e);
    send_byte(8'h55, 24'h0, e);
    bus_write(BASE, 32'h0000_0077, e);
    bus_read(STAT, rd);
    check_eq("ovf_set_status", rd, 32'h0000_040D);
    bus_write(STAT, 32'h0000_0008, e);
    bus_read(STAT, rd);
    check_eq("ovf_clear_status", rd, 32'h0000_0405);
    bus_write(32'h0000_1008, 32'h0000_0066, e);
    bus_write(32'h0000_1001, 32'h0000_0066, e);
    bus_read(STAT, rd);
    check_eq("unmapped_write_status", rd, 32'h0000_0405);
    while (cyc < n0 + FRAME) idle(1);
    send_byte(8'h88, 24'h0, e);
    check_eq("popwrite_edge", 32'(e), 32'(n0 + FRAME + 1));
    bus_read(STAT, rd);
    check_eq("popwrite_status", rd, 32'h0000_0405);
    wait_idle("ovf");

    // Reset in the middle of the data bits
    idle(3);
    send_byte(8'h3C, 24'h0, n);
    wait_neg(n + 15);
    reset = 1'b0;
    exp_q.delete();
    bus_write(BASE, 32'h0000_0099, e);
    check_eq("midreset_tx", {31'd0, tx}, 32'd1);
    bus_read(STAT, rd);
    check_eq("midreset_status", rd, 32'h0000_0002);
    check_eq("midreset_busy", {31'd0, busy}, 32'd0);
    idle(1);
    reset = 1'b1;
    idle(2);
    bus_read(STAT, rd);
    check_eq("postreset_status", rd, 32'h0000_0002);
    send_byte(8'h3C, 24'h0, n);
    wait_idle("postreset");

    // Parity-sensitive bytes (odd and even number of ones)
    send_byte(8'h07, 24'h0, e);
    send_byte(8'h03, 24'h0, e);
    wait_idle("parity");

    // Random bursts; five stores fit (one is popped at once, four queue)
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        send_byte(8'($urandom_range(0, 255)), 24'($urandom), e);
        gap = $urandom_range(0, 2);
        if (gap > 0) idle(gap);
      end
      wait_idle("rand");
      bus_read(STAT, rd);
      check_eq("rand_status", rd, 32'h0000_0002);
    end

    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
